// File: rtl/q_arith_pkg.sv
// Shared opcodes, FSM state encoding and sign-magnitude helpers for q_arith_unit.
package q_arith_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_t;

  // A zero magnitude is always reported as +0.
  function automatic logic norm_sign(input logic sign, input logic mag_zero);
    return sign & ~mag_zero;
  endfunction

endpackage

// File: rtl/q_div_seq.sv
// Bit-serial restoring divider: floor((dividend << Q) / divisor), one quotient bit per clock.
// The load edge performs the first iteration, so the quotient is ready N-1+Q edges after load.
module q_div_seq
  import q_arith_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [N-2:0]         dividend,
  input  logic [N-2:0]         divisor,
  output logic [N-2+Q:0]       quotient,
  output logic                 complete
);

  localparam int unsigned MW = N - 1;
  localparam int unsigned QW = N - 1 + Q;
  localparam int unsigned CW = $clog2(QW + 1);

  logic [QW-1:0] dq_q;
  logic [MW-1:0] rem_q;
  logic [MW-1:0] dvs_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  logic [QW-1:0] src_dq;
  logic [MW-1:0] src_rem;
  logic [MW-1:0] src_dvs;
  logic [MW:0]   rem_sh;
  logic [MW:0]   rem_sub;
  logic          fits;

  // On load the iteration works directly on the incoming operands.
  always_comb begin
    src_dq  = load ? {dividend, {Q{1'b0}}} : dq_q;
    src_rem = load ? '0 : rem_q;
    src_dvs = load ? divisor : dvs_q;
    rem_sh  = {src_rem, src_dq[QW-1]};
    rem_sub = rem_sh - {1'b0, src_dvs};
    fits    = (rem_sh >= {1'b0, src_dvs});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dq_q     <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      complete <= 1'b0;
    end else begin
      complete <= 1'b0;
      if (load || run_q) begin
        rem_q <= fits ? rem_sub[MW-1:0] : rem_sh[MW-1:0];
        dq_q  <= {src_dq[QW-2:0], fits};
      end
      if (load) begin
        dvs_q <= divisor;
        cnt_q <= CW'(QW - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q    <= 1'b0;
          complete <= 1'b1;
        end
      end
    end
  end

  assign quotient = dq_q;

endmodule

// File: rtl/q_arith_unit.sv
// Sign-magnitude Q-format add/divide unit with start/done handshake.
// Define Q_ARITH_SAT_EN to saturate overflowing results instead of wrapping.
module q_arith_unit
  import q_arith_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   opcode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         done_flag,
  output logic         busy,
  output logic         overflow
);

  localparam int unsigned MW = N - 1;
  localparam int unsigned QW = N - 1 + Q;

  state_t        state_q, state_d;
  logic [N-1:0]  c_q, c_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          dsign_q, dsign_d;
  logic          div_load_c;

  logic [MW-1:0] ma, mb;
  logic [MW:0]   mag_sum;
  logic [MW-1:0] add_raw, add_mag;
  logic          add_sign, add_carry;
  logic [N-1:0]  add_res;

  logic [QW-1:0] quot;
  logic          div_complete;
  logic          div_ovf;
  logic [MW-1:0] div_mag;
  logic [N-1:0]  div_res;

  assign ma      = a[MW-1:0];
  assign mb      = b[MW-1:0];
  assign mag_sum = {1'b0, ma} + {1'b0, mb};

  // Magnitude adder: add on equal signs, otherwise larger minus smaller.
  always_comb begin
    add_sign  = a[N-1];
    add_raw   = mag_sum[MW-1:0];
    add_carry = 1'b0;
    if (a[N-1] == b[N-1]) begin
      add_carry = mag_sum[MW];
    end else if (ma >= mb) begin
      add_raw = ma - mb;
    end else begin
      add_raw  = mb - ma;
      add_sign = b[N-1];
    end
  end

  assign div_ovf = (quot[QW-1:MW] != '0);

`ifdef Q_ARITH_SAT_EN
  assign add_mag = add_carry ? '1 : add_raw;
  assign div_mag = div_ovf ? '1 : quot[MW-1:0];
`else
  assign add_mag = add_raw;
  assign div_mag = quot[MW-1:0];
`endif

  assign add_res = {norm_sign(add_sign, add_mag == '0), add_mag};
  assign div_res = {norm_sign(dsign_q, div_mag == '0), div_mag};

  q_div_seq #(.N(N), .Q(Q)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load_c),
    .dividend (ma),
    .divisor  (mb),
    .quotient (quot),
    .complete (div_complete)
  );

  // Next-state and registered-output values; ADD and DONE are the done_flag cycles.
  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    dsign_d    = dsign_q;
    div_load_c = 1'b0;
    case (state_q)
      IDLE, ADD, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          done_d = 1'b1;
          case (opcode)
            OP_ADD: begin
              state_d = ADD;
              c_d     = add_res;
              ovf_d   = add_carry;
            end
            OP_DIV: begin
              if (mb == '0) begin
                state_d = DONE;
                c_d     = {a[N-1], {MW{1'b1}}};
                ovf_d   = 1'b1;
              end else begin
                state_d    = DIV;
                done_d     = 1'b0;
                busy_d     = 1'b1;
                dsign_d    = a[N-1] ^ b[N-1];
                div_load_c = 1'b1;
              end
            end
            default: begin
              state_d = DONE;
              c_d     = '0;
              ovf_d   = 1'b0;
            end
          endcase
        end
      end
      DIV: begin
        if (div_complete) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          c_d     = div_res;
          ovf_d   = div_ovf;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dsign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dsign_q <= dsign_d;
    end
  end

  assign c         = c_q;
  assign overflow  = ovf_q;
  assign done_flag = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_q_arith_unit.sv
// Directed testbench for q_arith_unit (N=32, Q=15).
module tb_q_arith_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  opcode;
  logic [31:0] a, b, c;
  logic        done_flag, busy, overflow;

  int tests = 0;
  int fails = 0;

  q_arith_unit #(.N(32), .Q(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .c         (c),
    .done_flag (done_flag),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Issue one request; lat counts cycles from the accepting edge to done_flag (-1 on timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    start = 1'b1; opcode = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; opcode = 2'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!done_flag && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!done_flag) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; opcode = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({c, done_flag, busy, overflow} !== 35'd0) begin
      fails++; $display("FAIL reset_state: c=%h done=%b busy=%b ovf=%b expected all 0", c, done_flag, busy, overflow);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_add();
    int lat; bit bok;
    logic [31:0] av [3] = '{32'h0000C000, 32'h0000C000, 32'h00008000};
    logic [31:0] bv [3] = '{32'h00012000, 32'h80012000, 32'h80008000};
    logic [31:0] ev [3] = '{32'h0001E000, 32'h80006000, 32'h00000000};
    for (int i = 0; i < 3; i++) begin
      run_op(2'b00, av[i], bv[i], lat, bok);
      tests++;
      if (lat !== 1) begin fails++; $display("FAIL add_latency[%0d]: got %0d expected 1", i, lat); end
      tests++;
      if (c !== ev[i] || overflow !== 1'b0) begin
        fails++; $display("FAIL add_result[%0d]: c=%h ovf=%b expected c=%h ovf=0", i, c, overflow, ev[i]);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (done_flag !== 1'b0) begin fails++; $display("FAIL add_done_pulse: done=%b expected 0", done_flag); end
  endtask

  task automatic test_div();
    int lat; bit bok;
    logic [31:0] exp_ovf_c;
    run_op(2'b10, 32'h00018000, 32'h00010000, lat, bok);
    tests++;
    if (lat !== 47) begin fails++; $display("FAIL div_latency: got %0d expected 47", lat); end
    tests++;
    if (!bok) begin fails++; $display("FAIL div_busy: busy dropped before done, expected held high"); end
    tests++;
    if (c !== 32'h0000C000 || overflow !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL div_3_over_2: c=%h ovf=%b busy=%b expected c=0000c000 ovf=0 busy=0", c, overflow, busy);
    end
    run_op(2'b10, 32'h80008000, 32'h00020000, lat, bok);
    tests++;
    if (lat !== 47 || c !== 32'h80002000 || overflow !== 1'b0) begin
      fails++; $display("FAIL div_neg: lat=%0d c=%h ovf=%b expected lat=47 c=80002000 ovf=0", lat, c, overflow);
    end
`ifdef Q_ARITH_SAT_EN
    exp_ovf_c = 32'h7FFFFFFF;
`else
    exp_ovf_c = 32'h7FFF8000;
`endif
    run_op(2'b10, 32'h7FFFFFFF, 32'h00000001, lat, bok);
    tests++;
    if (lat !== 47 || c !== exp_ovf_c || overflow !== 1'b1) begin
      fails++; $display("FAIL div_overflow: lat=%0d c=%h ovf=%b expected lat=47 c=%h ovf=1", lat, c, overflow, exp_ovf_c);
    end
  endtask

  task automatic test_boundary();
    int lat; bit bok;
    logic [31:0] exp_c;
    run_op(2'b10, 32'h00008000, 32'h00000000, lat, bok);
    tests++;
    if (lat !== 1 || c !== 32'h7FFFFFFF || overflow !== 1'b1) begin
      fails++; $display("FAIL div_by_zero: lat=%0d c=%h ovf=%b expected lat=1 c=7fffffff ovf=1", lat, c, overflow);
    end
    run_op(2'b10, 32'h80004000, 32'h80000000, lat, bok);
    tests++;
    if (lat !== 1 || c !== 32'hFFFFFFFF || overflow !== 1'b1) begin
      fails++; $display("FAIL div_by_zero_neg: lat=%0d c=%h ovf=%b expected lat=1 c=ffffffff ovf=1", lat, c, overflow);
    end
`ifdef Q_ARITH_SAT_EN
    exp_c = 32'h7FFFFFFF;
`else
    exp_c = 32'h00000000;
`endif
    run_op(2'b00, 32'h7FFFFFFF, 32'h00000001, lat, bok);
    tests++;
    if (lat !== 1 || c !== exp_c || overflow !== 1'b1) begin
      fails++; $display("FAIL add_overflow: lat=%0d c=%h ovf=%b expected lat=1 c=%h ovf=1", lat, c, overflow, exp_c);
    end
  endtask

  task automatic test_reserved();
    int lat; bit bok;
    run_op(2'b01, 32'h00018000, 32'h00010000, lat, bok);
    tests++;
    if (lat !== 1 || c !== 32'h0 || overflow !== 1'b0) begin
      fails++; $display("FAIL reserved_01: lat=%0d c=%h ovf=%b expected lat=1 c=0 ovf=0", lat, c, overflow);
    end
    run_op(2'b00, 32'h00008000, 32'h00008000, lat, bok);
    run_op(2'b11, 32'h00018000, 32'h00010000, lat, bok);
    tests++;
    if (lat !== 1 || c !== 32'h0 || overflow !== 1'b0) begin
      fails++; $display("FAIL reserved_11: lat=%0d c=%h ovf=%b expected lat=1 c=0 ovf=0", lat, c, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit bok;
    run_op(2'b00, 32'h0000C000, 32'h00012000, lat, bok);
    start = 1'b1; opcode = 2'b00; a = 32'h80010000; b = 32'h80008000;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (done_flag !== 1'b1 || c !== 32'h80018000 || overflow !== 1'b0) begin
      fails++; $display("FAIL back_to_back: done=%b c=%h ovf=%b expected done=1 c=80018000 ovf=0", done_flag, c, overflow);
    end
  endtask

  task automatic test_start_mid_div();
    int cyc = 1; int pulses = 0; int first = -1;
    logic [31:0] first_c = '0;
    @(negedge clk);
    start = 1'b1; opcode = 2'b10; a = 32'h00018000; b = 32'h00010000;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 80) begin
      if (done_flag) begin
        pulses++;
        if (first < 0) begin first = cyc; first_c = c; end
      end
      start = (cyc == 10);
      opcode = 2'b00; a = 32'h00001000; b = 32'h00001000;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    tests++;
    if (pulses !== 1 || first !== 47 || first_c !== 32'h0000C000) begin
      fails++; $display("FAIL start_mid_div: pulses=%0d at=%0d c=%h expected 1 pulse at 47 c=0000c000", pulses, first, first_c);
    end
  endtask

  task automatic test_reset_mid_div();
    int pulses = 0;
    @(negedge clk);
    start = 1'b1; opcode = 2'b10; a = 32'h00018000; b = 32'h00010000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL reset_mid_div_busy: busy=%b expected 1", busy); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || c !== 32'h0 || done_flag !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL reset_mid_div: busy=%b c=%h done=%b ovf=%b expected all 0", busy, c, done_flag, overflow);
    end
    @(negedge clk); reset = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done_flag) pulses++;
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL reset_mid_div_done: pulses=%0d expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_boundary();
    test_reserved();
    test_back_to_back();
    test_start_mid_div();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/q_arith_unit.md
Name: q_arith_unit

Overview:
- Signed fixed-point arithmetic unit for the fptop datapath.
- Operands are sign-magnitude Q-format words: bit N-1 is the sign, bits N-2:0 are the magnitude, and the low Q bits are fractional.
- Addition takes one cycle. Division is a bit-serial restoring divider with a start/done handshake.
- Sits between the operand registers and the result bus. Opcode selects the operation.

Parameters:
- N, 32, total word width including the sign bit.
- Q, 15, number of fractional bits; must satisfy 1 <= Q <= N-2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only while busy=0.
- opcode  in  2  00=add, 01=mul (reserved), 10=div, 11=reserved.
- a  in  N  operand A, sign-magnitude Q-format.
- b  in  N  operand B (divisor for div).
- c  out  N  registered result.
- done_flag  out  1  one-cycle pulse when c/overflow update.
- busy  out  1  high from the accepted start until done_flag.
- overflow  out  1  registered with c; high if the result is not representable or on divide-by-zero.

Behaviour:
- Reset (sync, active-high): c=0, done_flag=0, busy=0, overflow=0, FSM to IDLE. Reset mid-division aborts; no done_flag is produced.
- FSM states:
  - IDLE: accepts start.
  - ADD: single cycle.
  - DIV: iterates.
  - DONE: pulses done_flag, returns to IDLE.
- The edge that accepts start latches a, b and opcode; later input changes are ignored. start is ignored while busy=1.
- Add (opcode 00):
  - Equal signs: add magnitudes; sign = common sign.
  - Differing signs: subtract the smaller magnitude from the larger; sign = sign of the larger.
  - A zero magnitude always gets sign 0 (no negative zero).
  - Magnitude carry out of bit N-2 sets overflow=1; the magnitude is handled per the Optional Feature.
  - Latency 1: c and done_flag are valid in the cycle after the accepting edge.
- Div (opcode 10):
  - Quotient magnitude = floor((|a| << Q) / |b|), computed one bit per clock over N-1+Q iterations.
  - Result sign = sign(a) XOR sign(b); a zero quotient gets sign 0.
  - Total latency N+Q cycles (47 by default) from the accepting edge to the cycle with done_flag=1.
  - Quotient bits above N-2 set overflow=1; the magnitude is handled per the Optional Feature.
  - Divide-by-zero (|b|=0): no iteration. Latency 1; c = max magnitude (all ones) with sign(a); overflow=1.
- Reserved opcodes (01, 11): latency 1, c=0, overflow=0, done_flag pulses.
- done_flag is high for exactly one cycle per accepted start. c and overflow hold until the next completion.
- busy goes high on the cycle after the accepting edge and falls together with done_flag.
- Back-to-back: a start in the cycle where done_flag=1 (busy=0) is accepted.

Optional Feature:
- Macro Q_ARITH_SAT_EN.
- Defined: on add or div overflow, c = max representable magnitude (all ones) with the computed sign.
- Undefined: c keeps the low N-1 magnitude bits (wrap-around) with the computed sign, normalised to +0 if zero.
- overflow=1 in both cases.

Decomposition:
- Package q_arith_pkg:
  - opcode localparams OP_ADD=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_RSVD=2'b11;
  - FSM state enum {IDLE, ADD, DIV, DONE};
  - helper function for sign-magnitude zero normalisation.
- One sub-module, q_div_seq: the iterative restoring divider with internal start/complete, instantiated by q_arith_unit. The adder stays inline as combinational logic.

Test Plan (N=32, Q=15):
- Add positives: a=0x0000C000 (1.5), b=0x00012000 (2.25) -> c=0x0001E000 (3.75), overflow=0, done_flag 1 cycle after the accepting edge.
- Add mixed signs: a=0x0000C000, b=0x80012000 (-2.25) -> c=0x80006000 (-0.75); a=0x00008000, b=0x80008000 -> c=0x00000000 (no negative zero).
- Divide:
  - a=0x00018000 (3.0), b=0x00010000 (2.0) -> c=0x0000C000, done_flag exactly 47 cycles after the accepting edge, busy high throughout.
  - a=0x80008000 (-1.0), b=0x00020000 (4.0) -> c=0x80002000 (-0.25).
- Divide-by-zero: a=0x00008000, b=0 -> c=0x7FFFFFFF, overflow=1, latency 1. Add overflow: a=0x7FFFFFFF, b=0x00000001 -> overflow=1, c=0x7FFFFFFF with Q_ARITH_SAT_EN, else c=0x00000000.
- Control:
  - start pulsed mid-division is ignored (single done_flag, result unchanged);
  - reset asserted mid-division -> next cycle busy=0, c=0, no done_flag;
  - opcode 01 -> c=0, overflow=0, done_flag after 1 cycle.
